// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command sender.
// UART_CMD_CHECKSUM_EN lengthens each frame by one trailing XOR checksum byte.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h56;
    localparam logic [7:0] CMD_READ  = 8'h55;

`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [3:0] WRITE_LEN = 4'd10;
    localparam logic [3:0] READ_LEN  = 4'd6;
`else
    localparam logic [3:0] WRITE_LEN = 4'd9;
    localparam logic [3:0] READ_LEN  = 4'd5;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StGap,
        StDone
    } state_e;

    // Byte idx of a frame: opcode, addr LSB..MSB, then data LSB..MSB.
    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [7:0]  opcode,
                                              input logic [31:0] addr,
                                              input logic [31:0] data);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = opcode;
            4'd1:    b = addr[7:0];
            4'd2:    b = addr[15:8];
            4'd3:    b = addr[23:16];
            4'd4:    b = addr[31:24];
            4'd5:    b = data[7:0];
            4'd6:    b = data[15:8];
            4'd7:    b = data[23:16];
            4'd8:    b = data[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_sender_if.sv
// Command request handshake between a test master and the UART command sender.
interface uart_cmd_sender_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a new byte may be started in the last cycle of the stop bit,
// so consecutive bytes can run back-to-back.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk50MHz,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       idle,
    output logic       phase_end
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic            busy_q, busy_d;
    logic [3:0]      bit_q, bit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            cnt_last;

    assign cnt_last = (cnt_q == CntLast);
    assign tx       = tx_q;

    // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit.
    always_comb begin
        phase_end = busy_q && cnt_last && ((bit_q == 4'd0) || (bit_q == 4'd8) || (bit_q == 4'd9));
        idle      = !busy_q || (cnt_last && (bit_q == 4'd9));
    end

    always_comb begin
        busy_d  = busy_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (start && idle) begin
            busy_d  = 1'b1;
            bit_d   = 4'd0;
            cnt_d   = '0;
            shift_d = data;
            tx_d    = 1'b0;
        end else if (busy_q) begin
            if (cnt_last) begin
                cnt_d = '0;
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    bit_d  = 4'd0;
                    tx_d   = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            busy_q  <= 1'b0;
            bit_q   <= 4'd0;
            cnt_q   <= '0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_cmd_sender.sv
// Frames read/write memory commands and sends them as UART 8N1 bytes with idle gaps.
// UART_CMD_CHECKSUM_EN appends an XOR-of-all-bytes checksum to every frame.
module uart_cmd_sender
    import uart_cmd_pkg::*;
#(
    parameter int unsigned INPUT_CLOCK  = 50000000,
    parameter int unsigned UART_BAUD    = 9600,
    parameter int unsigned CLKS_PER_BIT = INPUT_CLOCK / UART_BAUD,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic                clk50MHz,
    input  logic                reset,
    uart_cmd_sender_if.slave    cmd,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int unsigned GapCycles = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GapW      = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      idx_q, idx_d;
    logic [GapW-1:0] gap_q, gap_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic       ready;
    logic       accept;
    logic       ser_start;
    logic       ser_idle;
    logic       ser_phase_end;
    logic [7:0] ser_byte;
    logic [7:0] next_byte;
    logic [3:0] next_idx;
    logic [3:0] last_idx;

    assign accept   = cmd.cmd_valid && ready;
    assign next_idx = idx_q + 4'd1;
    assign last_idx = (write_q ? WRITE_LEN : READ_LEN) - 4'd1;

    always_comb begin
        next_byte = frame_byte(next_idx, write_q ? CMD_WRITE : CMD_READ, addr_q, data_q);
`ifdef UART_CMD_CHECKSUM_EN
        if (next_idx == last_idx) begin
            next_byte = csum_q;
        end
`endif
    end

    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // The opcode is handed to the serializer in the accept cycle so the start bit
    // appears in the very next cycle.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        data_d    = data_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
`ifdef UART_CMD_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        ser_start = 1'b0;
        ser_byte  = next_byte;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    ser_start = 1'b1;
                    ser_byte  = cmd.cmd_write ? CMD_WRITE : CMD_READ;
                    write_d   = cmd.cmd_write;
                    addr_d    = cmd.cmd_addr;
                    data_d    = cmd.cmd_data;
                    idx_d     = 4'd0;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d    = ser_byte;
`endif
                    state_d   = StStart;
                end else begin
                    state_d = StIdle;
                end
            end
            StStart: begin
                if (ser_phase_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (ser_phase_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (ser_phase_end) begin
                    if (idx_q == last_idx) begin
                        state_d = StDone;
                    end else if (GAP_BITS == 0) begin
                        ser_start = 1'b1;
                        idx_d     = next_idx;
`ifdef UART_CMD_CHECKSUM_EN
                        csum_d    = csum_q ^ next_byte;
`endif
                        state_d   = StStart;
                    end else begin
                        gap_d   = '0;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    ser_start = 1'b1;
                    idx_d     = next_idx;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d    = csum_q ^ next_byte;
`endif
                    state_d   = StStart;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = ser_idle;
                busy  = 1'b0;
            end
            StDone: begin
                ready = ser_idle;
                busy  = 1'b0;
                done  = 1'b1;
            end
            default: ;
        endcase
        cmd.cmd_ready = ready;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk50MHz (clk50MHz),
        .reset    (reset),
        .start    (ser_start),
        .data     (ser_byte),
        .tx       (tx),
        .idle     (ser_idle),
        .phase_end(ser_phase_end)
    );

endmodule
